ldpc_bitflip_corrector: RTL and testbench

Iterative hard-decision bit-flipping corrector for the 15-bit cyclic LDPC codeword. It sits directly downstream of the syndrome detector. It accepts one channel codeword at a time over a valid/ready handshake and iterates syndrome evaluation and bit flipping until the syndrome is zero or an iteration cap is reached. It then presents the corrected 15-bit word, a success flag and the iteration count to the next stage.

---
 rtl/ldpc_bitflip_corrector.sv | 87 ++++++++
 tb/tb_ldpc_bitflip_corrector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ldpc_bitflip_corrector.sv
// ldpc_bitflip_corrector: iterative hard-decision bit-flip decoder for the 15-bit cyclic LDPC code.
// Accepts one word, flips bits until the syndrome clears or the iteration cap is hit, then holds the result.
module ldpc_bitflip_corrector #(
  parameter logic [14:0] H_ROW0   = 15'b000_0000_1101_0001,
  parameter int unsigned FLIP_TH  = 3,
  parameter int unsigned MAX_ITER = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] c_out,
  output logic        ok,
  output logic [3:0]  iters
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t      state_q, state_d;
  logic [14:0] w_q, w_d, c_out_q, c_out_d, s, flip;
  logic [3:0]  cnt_q, cnt_d, iters_q, iters_d;
  logic        ok_q, ok_d;
  logic [2:0]  u [15];
  // Check j covers bits j+p; bit k is watched by checks k-p, over every tap p.
  always_comb begin
    s = '0;
    flip = '0;
    for (int j = 0; j < 15; j++)
      for (int p = 0; p < 15; p++)
        if (H_ROW0[p]) s[j] = s[j] ^ w_q[(j + p) % 15];
    for (int k = 0; k < 15; k++) begin
      u[k] = '0;
      for (int p = 0; p < 15; p++)
        if (H_ROW0[p]) u[k] = u[k] + {2'b00, s[(k + 15 - p) % 15]};
      flip[k] = u[k] >= 3'(FLIP_TH);
    end
  end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    cnt_d = cnt_q;
    c_out_d = c_out_q;
    ok_d = ok_q;
    iters_d = iters_q;
    case (state_q)
      IDLE: if (in_valid) begin
        w_d = c;
        cnt_d = '0;
        state_d = ITER;
      end
      ITER: if (s == '0 || cnt_q == 4'(MAX_ITER)) begin
        state_d = DONE;
        c_out_d = w_q;
        ok_d = s == '0;
        iters_d = cnt_q;
      end else begin
        w_d = w_q ^ flip;
        cnt_d = cnt_q + 4'd1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q <= '0;
      cnt_q <= '0;
      c_out_q <= '0;
      ok_q <= 1'b0;
      iters_q <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
      c_out_q <= c_out_d;
      ok_q <= ok_d;
      iters_q <= iters_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign c_out = c_out_q;
  assign ok = ok_q;
  assign iters = iters_q;
endmodule

// File: tb/tb_ldpc_bitflip_corrector.sv
// tb_ldpc_bitflip_corrector: directed vectors against the bit-flip corrector, default cap and cap=0 instances.
module tb_ldpc_bitflip_corrector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [14:0] c = '0;
  logic        sel = 1'b0;
  logic        in_ready0, out_valid0, ok0, in_ready1, out_valid1, ok1;
  logic [14:0] c_out0, c_out1;
  logic [3:0]  iters0, iters1;
  logic        r_in_ready, r_out_valid, r_ok;
  logic [14:0] r_c_out;
  logic [3:0]  r_iters;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ldpc_bitflip_corrector dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(in_ready0), .c(c),
    .out_valid(out_valid0), .out_ready(out_ready), .c_out(c_out0), .ok(ok0), .iters(iters0)
  );
  ldpc_bitflip_corrector #(.MAX_ITER(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(in_ready1), .c(c),
    .out_valid(out_valid1), .out_ready(out_ready), .c_out(c_out1), .ok(ok1), .iters(iters1)
  );

  assign r_in_ready  = sel ? in_ready1  : in_ready0;
  assign r_out_valid = sel ? out_valid1 : out_valid0;
  assign r_c_out     = sel ? c_out1     : c_out0;
  assign r_ok        = sel ? ok1        : ok0;
  assign r_iters     = sel ? iters1     : iters0;

  typedef struct {
    logic [14:0] cw;
    logic [14:0] exp_c;
    logic        exp_ok;
    logic [3:0]  exp_it;
  } vec_t;
  vec_t vec [20];

  task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %0h expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic run_word(input logic s_, input logic [14:0] cw, input logic [14:0] ec,
                          input logic eok, input logic [3:0] eit, input string tag);
    int cyc;
    sel = s_;
    @(negedge clk);
    chk(tag, "in_ready", 32'(r_in_ready), 1);
    in_valid = 1'b1;
    c = cw;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!r_out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(tag, "latency", 32'(cyc), 32'(2 + int'(eit)));
    chk(tag, "c_out", 32'(r_c_out), 32'(ec));
    chk(tag, "ok", 32'(r_ok), 32'(eok));
    chk(tag, "iters", 32'(r_iters), 32'(eit));
    @(posedge clk);
    #1;
    chk(tag, "out_valid_drop", 32'(r_out_valid), 0);
  endtask

  initial begin
    int cyc;
    logic seen;
    vec[0] = '{15'h0000, 15'h0000, 1'b1, 4'd0};
    vec[1] = '{15'h7FFF, 15'h7FFF, 1'b1, 4'd0};
    for (int i = 0; i < 15; i++) vec[2 + i] = '{15'(1 << i), 15'h0000, 1'b1, 4'd1};
    vec[17] = '{15'h0011, 15'h0000, 1'b1, 4'd1};
    vec[18] = '{15'h0003, 15'h0000, 1'b1, 4'd1};
    vec[19] = '{15'h3FFE, 15'h7FFF, 1'b1, 4'd1};

    #1;
    chk("por", "in_ready", 32'(in_ready0), 1);
    chk("por", "out_valid", 32'(out_valid0), 0);
    chk("por", "c_out", 32'(c_out0), 0);
    chk("por", "iters", 32'(iters0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) run_word(1'b0, vec[i].cw, vec[i].exp_c, vec[i].exp_ok, vec[i].exp_it, $sformatf("vec%0d", i));

    // Reset while in ITER: outputs must clear immediately (last result was 7FFF/ok/1).
    sel = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    c = 15'h0003;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rst_mid", "in_iter", 32'(in_ready0), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "in_ready", 32'(in_ready0), 1);
    chk("rst_mid", "out_valid", 32'(out_valid0), 0);
    chk("rst_mid", "c_out", 32'(c_out0), 0);
    chk("rst_mid", "ok", 32'(ok0), 0);
    chk("rst_mid", "iters", 32'(iters0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid0 | ~in_ready0;
    end
    chk("rst_mid", "quiet_after", 32'(seen), 0);

    run_word(1'b1, 15'h0001, 15'h0001, 1'b0, 4'd0, "cap1");
    run_word(1'b1, 15'h0003, 15'h0003, 1'b0, 4'd0, "cap2");
    run_word(1'b1, 15'h7FFF, 15'h7FFF, 1'b1, 4'd0, "cap_clean");

    // Backpressure: result held for 5 cycles while a stray word is offered.
    sel = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    c = 15'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp", "latency", 32'(cyc), 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      c = 15'h1234;
      @(posedge clk);
      #1;
      chk("bp", "out_valid", 32'(out_valid0), 1);
      chk("bp", "in_ready", 32'(in_ready0), 0);
      chk("bp", "c_out", 32'(c_out0), 0);
      chk("bp", "ok", 32'(ok0), 1);
      chk("bp", "iters", 32'(iters0), 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp", "released_valid", 32'(out_valid0), 0);
    chk("bp", "released_ready", 32'(in_ready0), 1);
    @(posedge clk);
    #1;
    chk("bp", "still_idle", 32'(in_ready0), 1);
    chk("bp", "no_second", 32'(out_valid0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
